shadow_bank_arbiter: RTL and testbench
======================================

# shadow_bank_arbiter

Shares a bank of shadow registers between several requesters (e.g. core CSR instruction path and debug-module abstract commands). It arbitrates requests, performs write/set/clear/read operations against the bank's current values, and drives each register's write strobe and input bus. One request is in flight at a time, with a single-entry response stage and full throughput of one operation per cycle when responses are not back-pressured. It sits between the requesters and an array of `shadow_reg` instances.

## Interface
- `NumRegs`, 4: number of shadow registers in the bank.
- `Width`, 32: register data width.
- `NumReq`, 2: number of requesters.
- `AddrWidth`, 4: request address width; must satisfy 2^AddrWidth ≥ NumRegs.
- One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous active-high reset.
- `req_valid` in NumReq: per-requester request valid.
- `req_ready` out NumReq: per-requester grant; transfer when valid & ready.
- `req_addr` in NumReq*AddrWidth: register index, requester i at slice i.
- `req_op` in NumReq*2: operation (`op_e`), requester i at slice i.
- `req_wdata` in NumReq*Width: write data / bit mask.
- `rsp_valid` out 1: response stage holds a result.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_id` out $clog2(NumReq) (min 1): index of the originating requester.
- `rsp_rdata` out Width: register value before the operation.
- `rsp_err` out 1: address ≥ NumRegs.
- `reg_out` in NumRegs*Width: current `out` of each shadow register.
- `reg_write` out NumRegs: one-hot write strobe to the bank.
- `reg_in` out Width: shared data to every register's `in`.

## Operation
- Ops: WRITE → new = wdata; SET → old | wdata; CLEAR → old & ~wdata; READ → no write.
- Stage is free when empty or firing (`rsp_valid & rsp_ready`). When free and any `req_valid` is high, exactly one requester gets `req_ready`; otherwise all `req_ready` are 0. `req_ready` is combinational from `req_valid`, stage state, and `rsp_ready`.
- An accepted request is latched into the stage: valid, id, addr, op, wdata, err = (addr ≥ NumRegs).
- The commit occurs in the firing cycle:
  - `reg_write[addr]` = 1 iff op ≠ READ and !err.
  - `reg_in` = new value computed combinationally from `reg_out[addr]` in that cycle.
  - `rsp_rdata` = `reg_out[addr]`, or 0 when err.
- `reg_write` is 0 whenever the stage does not fire; `reg_in` is don't-care then and is driven to 0.
- Back-to-back operations on the same register are hazard-free. The shadow register updates at the end of the firing cycle, and the next op reads `reg_out` in its own, later firing cycle.
- Erroneous requests are accepted, return `rsp_err` = 1, and never write.

## Timing
- Reset: stage empty, `rsp_valid` = 0, `rsp_id`/`rsp_rdata`/`rsp_err` = 0, `reg_write` = 0, `reg_in` = 0, `req_ready` = 0, round-robin pointer = 0.
- Latency: request accepted in cycle N → `rsp_valid` in N+1. The write strobe is in the cycle `rsp_ready` is high (N+1 at the earliest).
- Throughput: 1 op/cycle while `rsp_ready` = 1.
- When the stage is held (`rsp_valid & !rsp_ready`), its contents and `reg_write` = 0 are held stable, and `req_ready` = 0.
- Reset asserted mid-operation discards the stage without a write; the held request is lost.

## Configuration
- `SHADOW_ARB_RR_EN` defined: round-robin arbitration. Search starts at the pointer; after a grant to i, the pointer becomes (i+1) mod NumReq; the pointer is unchanged if there is no grant.
- Undefined: fixed priority, lowest index wins; no pointer state.

## Structure
- Package `shadow_arb_pkg`: `op_e` (2-bit: OP_WRITE=0, OP_SET=1, OP_CLEAR=2, OP_READ=3) and the function computing the new value from (op, old, wdata).
- Sub-module `rr_arbiter` (NumReq request → one-hot grant, with advance input). Its pointer logic is compiled out without `SHADOW_ARB_RR_EN`.

## Test plan
- Requester 0 WRITE addr 1 data 0xDEADBEEF, `rsp_ready` = 1 → next cycle `reg_write` = 4'b0010, `reg_in` = 0xDEADBEEF, `rsp_rdata` = old value, `rsp_id` = 0.
- Register 2 = 0x000000F0; SET 0x0F, then CLEAR 0x30 back-to-back → `reg_in` 0xFF, then 0xCF; `rsp_rdata` 0xF0, then 0xFF.
- Both requesters valid continuously for 4 cycles with RR → grants 0,1,0,1; without the macro → 0,0,0,0.
- Request addr 5 with NumRegs = 4 → `rsp_err` = 1, `rsp_rdata` = 0, `reg_write` = 0.
- `rsp_ready` = 0 for 3 cycles with the stage full → `req_ready` = 0, response and `reg_write` = 0 held; write occurs in the cycle `rsp_ready` rises.
- `rst` asserted with the stage full and `rsp_ready` = 0 → `rsp_valid` drops immediately; no write is issued after release.

Source files
------------

// File: rtl/shadow_arb_pkg.sv
// Purpose: shared op encoding and new-value helper for the shadow register bank arbiter.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package shadow_arb_pkg;

    // Operations a requester can issue against one shadow register.
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    // Widest register the helper handles; callers zero-extend and truncate around it.
    localparam int unsigned ShadowMaxWidth = 64;

    // Value the register must take after applying op to its current contents.
    // READ returns the old value so the result is harmless if it is ever observed.
    function automatic logic [ShadowMaxWidth-1:0] shadow_new_val(
        input op_e                       op,
        input logic [ShadowMaxWidth-1:0] old_val,
        input logic [ShadowMaxWidth-1:0] wdata
    );
        logic [ShadowMaxWidth-1:0] res;
        case (op)
            OP_WRITE: res = wdata;
            OP_SET:   res = old_val | wdata;
            OP_CLEAR: res = old_val & ~wdata;
            default:  res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shadow_bank_arbiter_rr_arbiter.sv
// Purpose: pick one requester (one-hot grant); round-robin with SHADOW_ARB_RR_EN, else fixed priority.
// Latency: grant is combinational from req_i; pointer moves on the clock after advance_i.
// Backpressure: caller masks req_i when it cannot accept; no grant is produced for an all-zero request.
module rr_arbiter #(
    parameter int NumReq = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] req_i,
    input  logic              advance_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef SHADOW_ARB_RR_EN
    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic            found;

    // Search from the pointer upward, then wrap to the indices below it.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_q))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
                ptr_d    = (i == NumReq - 1) ? '0 : PtrW'(i + 1);
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_q))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
                ptr_d    = (i == NumReq - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    // Pointer moves past the winner only when a grant is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic found;
    logic unused_rr;

    assign unused_rr = clk ^ rst ^ advance_i;

    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/shadow_bank_arbiter.sv
// Purpose: arbitrate write/set/clear/read requests onto a shadow register bank (SHADOW_ARB_RR_EN selects round-robin).
// Latency: accept in cycle N -> rsp_valid in N+1; register strobe fires in the cycle the response is taken.
// Backpressure: single-entry response stage; req_ready drops while the stage is held by rsp_ready=0.
module shadow_bank_arbiter
    import shadow_arb_pkg::*;
#(
    parameter int NumRegs   = 4,
    parameter int Width     = 32,
    parameter int NumReq    = 2,
    parameter int AddrWidth = 4,
    localparam int IdW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumReq-1:0]           req_valid,
    output logic [NumReq-1:0]           req_ready,
    input  logic [NumReq*AddrWidth-1:0] req_addr,
    input  logic [NumReq*2-1:0]         req_op,
    input  logic [NumReq*Width-1:0]     req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IdW-1:0]              rsp_id,
    output logic [Width-1:0]            rsp_rdata,
    output logic                        rsp_err,
    input  logic [NumRegs*Width-1:0]    reg_out,
    output logic [NumRegs-1:0]          reg_write,
    output logic [Width-1:0]            reg_in
);

    // Response stage: one request in flight.
    logic                 vld_q;
    logic [IdW-1:0]       id_q;
    logic [AddrWidth-1:0] addr_q;
    op_e                  op_q;
    logic [Width-1:0]     wdata_q;
    logic                 err_q;

    logic                 fire;
    logic                 stage_free;
    logic                 any_gnt;
    logic [NumReq-1:0]    arb_req;
    logic [NumReq-1:0]    gnt;

    logic [IdW-1:0]       id_d;
    logic [AddrWidth-1:0] addr_d;
    op_e                  op_d;
    logic [Width-1:0]     wdata_d;
    logic                 err_d;

    logic [Width-1:0]     old_val;
    logic [Width-1:0]     new_val;
    logic                 do_write;

    assign fire       = vld_q & rsp_ready;
    assign stage_free = ~vld_q | rsp_ready;
    // Nothing is offered while reset holds the stage empty.
    assign arb_req    = req_valid & {NumReq{stage_free & ~rst}};
    assign any_gnt    = |gnt;
    assign req_ready  = gnt;

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (arb_req),
        .advance_i (any_gnt),
        .gnt_o     (gnt)
    );

    // Mux the granted requester's fields into the stage's next-state inputs.
    always_comb begin
        id_d    = '0;
        addr_d  = '0;
        op_d    = OP_WRITE;
        wdata_d = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                id_d    = IdW'(i);
                addr_d  = req_addr[i*AddrWidth +: AddrWidth];
                op_d    = op_e'(req_op[i*2 +: 2]);
                wdata_d = req_wdata[i*Width +: Width];
            end
        end
        err_d = (32'(addr_d) >= 32'(NumRegs));
    end

    // Load on grant (which can coincide with the previous entry firing), empty on a bare fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            op_q    <= OP_WRITE;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (any_gnt) begin
            vld_q   <= 1'b1;
            id_q    <= id_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end else if (fire) begin
            vld_q   <= 1'b0;
        end
    end

    // Current contents of the addressed register; the bank only changes on our own strobe.
    always_comb begin
        old_val = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (addr_q == AddrWidth'(i)) begin
                old_val = reg_out[i*Width +: Width];
            end
        end
    end

    assign new_val  = Width'(shadow_new_val(op_q, ShadowMaxWidth'(old_val),
                                            ShadowMaxWidth'(wdata_q)));
    assign do_write = fire & ~err_q & (op_q != OP_READ);

    // One-hot strobe, only in the cycle the response is consumed.
    always_comb begin
        reg_write = '0;
        for (int i = 0; i < NumRegs; i++) begin
            reg_write[i] = do_write && (addr_q == AddrWidth'(i));
        end
    end

    assign reg_in    = (fire & ~err_q) ? new_val : '0;
    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = (vld_q & ~err_q) ? old_val : '0;

endmodule

// File: tb/tb_shadow_bank_arbiter.sv
// Purpose: directed stimulus against shadow_bank_arbiter with a per-cycle reference model and literal spot checks.
// Latency: model expects response one cycle after acceptance, strobe in the consuming cycle.
// Backpressure: exercises held stage (rsp_ready low) and reset while full.
module tb_shadow_bank_arbiter;
    import shadow_arb_pkg::*;

    localparam int NumRegs   = 4;
    localparam int Width     = 32;
    localparam int NumReq    = 2;
    localparam int AddrWidth = 4;

    localparam logic [31:0] INIT0 = 32'hA5A5_0000;
    localparam logic [31:0] INIT1 = 32'h1234_5678;
    localparam logic [31:0] INIT2 = 32'h0000_00F0;
    localparam logic [31:0] INIT3 = 32'hCAFE_0003;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NumReq-1:0]           req_valid = '0;
    logic [NumReq-1:0]           req_ready;
    logic [NumReq*AddrWidth-1:0] req_addr = '0;
    logic [NumReq*2-1:0]         req_op = '0;
    logic [NumReq*Width-1:0]     req_wdata = '0;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b0;
    logic [0:0]                  rsp_id;
    logic [Width-1:0]            rsp_rdata;
    logic                        rsp_err;
    logic [NumRegs*Width-1:0]    reg_out;
    logic [NumRegs-1:0]          reg_write;
    logic [Width-1:0]            reg_in;

    // Behavioural shadow registers driven by the DUT strobe.
    logic [31:0] bank [NumRegs] = '{INIT0, INIT1, INIT2, INIT3};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shadow_bank_arbiter #(
        .NumRegs(NumRegs), .Width(Width), .NumReq(NumReq), .AddrWidth(AddrWidth)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_out(reg_out), .reg_write(reg_write), .reg_in(reg_in)
    );

    always_comb begin
        for (int i = 0; i < NumRegs; i++) reg_out[i*Width +: Width] = bank[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NumRegs; i++) if (reg_write[i]) bank[i] <= reg_in;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mdl [NumRegs] = '{INIT0, INIT1, INIT2, INIT3};
    logic        m_vld = 1'b0;
    int          m_id, m_addr, m_ptr, m_g;
    logic [1:0]  m_op;
    logic [31:0] m_wd, m_old, m_new;
    logic        m_err, m_fire, m_wr;

    function automatic logic req_bit(input logic [NumReq-1:0] v, input int k);
        return ((v >> k) & 1) != 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_vld = 1'b0;
            m_ptr = 0;
            chk("rst rsp_valid", rsp_valid, 0);
            chk("rst req_ready", req_ready, 0);
            chk("rst rsp_id", rsp_id, 0);
            chk("rst rsp_rdata", rsp_rdata, 0);
            chk("rst rsp_err", rsp_err, 0);
            chk("rst reg_write", reg_write, 0);
            chk("rst reg_in", reg_in, 0);
        end else begin
            m_g = -1;
            if (!m_vld || rsp_ready) begin
                for (int k = 0; k < NumReq; k++) begin
`ifdef SHADOW_ARB_RR_EN
                    if (m_g < 0 && req_bit(req_valid, (m_ptr + k) % NumReq)) m_g = (m_ptr + k) % NumReq;
`else
                    if (m_g < 0 && req_bit(req_valid, k)) m_g = k;
`endif
                end
            end
            chk("req_ready", req_ready, (m_g < 0) ? 0 : (64'd1 << m_g));

            m_err  = m_addr >= NumRegs;
            m_old  = (m_vld && !m_err) ? mdl[m_addr[1:0]] : 32'h0;
            m_fire = m_vld && rsp_ready;
            m_wr   = m_fire && !m_err && (m_op != 2'd3);
            case (m_op)
                2'd0:    m_new = m_wd;
                2'd1:    m_new = m_old | m_wd;
                2'd2:    m_new = m_old & ~m_wd;
                default: m_new = m_old;
            endcase
            chk("rsp_valid", rsp_valid, m_vld);
            chk("rsp_rdata", rsp_rdata, m_old);
            if (m_vld) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_err);
            end
            chk("reg_write", reg_write, m_wr ? (64'd1 << m_addr) : 0);
            if (m_wr) chk("reg_in", reg_in, m_new);
            if (!m_fire) chk("reg_in idle", reg_in, 0);

            if (m_wr) mdl[m_addr[1:0]] = m_new;
            if (m_g >= 0) begin
                m_vld  = 1'b1;
                m_id   = m_g;
                m_addr = int'((req_addr >> (m_g * AddrWidth)) & 4'hF);
                m_op   = 2'((req_op >> (m_g * 2)) & 2'h3);
                m_wd   = 32'((req_wdata >> (m_g * Width)) & 64'hFFFF_FFFF);
                m_ptr  = (m_g + 1) % NumReq;
            end else if (m_fire) begin
                m_vld = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [3:0] a,
                           input op_e op, input logic [31:0] d);
        req_valid[r]            = v;
        req_addr[r*4 +: 4]      = a;
        req_op[r*2 +: 2]        = op;
        req_wdata[r*32 +: 32]   = d;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 4'd0, OP_READ, 32'h0);
        set_req(1, 1'b0, 4'd0, OP_READ, 32'h0);
    endtask

    logic [1:0] exp_gnt [4];

    initial begin
        // Reset
        tick(); tick();
        #1;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset reg_write", reg_write, 0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;

        // WRITE addr1 from requester 0
        set_req(0, 1'b1, 4'd1, OP_WRITE, 32'hDEADBEEF);
        #1 chk("t1 req_ready", req_ready, 2'b01);
        tick(); idle();
        #1;
        chk("t1 rsp_valid", rsp_valid, 1);
        chk("t1 reg_write", reg_write, 4'b0010);
        chk("t1 reg_in", reg_in, 32'hDEADBEEF);
        chk("t1 rsp_rdata", rsp_rdata, INIT1);
        chk("t1 rsp_id", rsp_id, 0);
        tick();
        chk("t1 bank1", bank[1], 32'hDEADBEEF);

        // SET then CLEAR back-to-back on register 2
        set_req(1, 1'b1, 4'd2, OP_SET, 32'h0000_000F);
        tick();
        set_req(1, 1'b1, 4'd2, OP_CLEAR, 32'h0000_0030);
        #1;
        chk("t2 set reg_in", reg_in, 32'hFF);
        chk("t2 set rdata", rsp_rdata, 32'hF0);
        chk("t2 set reg_write", reg_write, 4'b0100);
        chk("t2 clr req_ready", req_ready, 2'b10);
        tick(); idle();
        #1;
        chk("t2 clr reg_in", reg_in, 32'hCF);
        chk("t2 clr rdata", rsp_rdata, 32'hFF);
        tick();

        // Both requesters valid for 4 cycles
`ifdef SHADOW_ARB_RR_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        set_req(0, 1'b1, 4'd0, OP_READ, 32'h0);
        set_req(1, 1'b1, 4'd3, OP_READ, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("t3 grant%0d", c), req_ready, exp_gnt[c]);
            tick();
        end
        idle();
        tick();

        // Out-of-range address
        set_req(0, 1'b1, 4'd5, OP_WRITE, 32'h0000_FFFF);
        tick(); idle();
        #1;
        chk("t4 rsp_valid", rsp_valid, 1);
        chk("t4 rsp_err", rsp_err, 1);
        chk("t4 rsp_rdata", rsp_rdata, 0);
        chk("t4 reg_write", reg_write, 0);
        tick();

        // Held stage for 3 cycles
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd3, OP_WRITE, 32'h55);
        #1 chk("t5 accept", req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 4'd0, OP_READ, 32'h0);
        set_req(1, 1'b1, 4'd0, OP_READ, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t5 held ready%0d", c), req_ready, 2'b00);
            chk($sformatf("t5 held valid%0d", c), rsp_valid, 1);
            chk($sformatf("t5 held write%0d", c), reg_write, 0);
            chk($sformatf("t5 held rdata%0d", c), rsp_rdata, INIT3);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5 release write", reg_write, 4'b1000);
        chk("t5 release reg_in", reg_in, 32'h55);
        chk("t5 release ready", req_ready, 2'b10);
        tick(); idle();
        #1;
        chk("t5 read id", rsp_id, 1);
        chk("t5 read rdata", rsp_rdata, INIT0);
        tick();
        chk("t5 bank3", bank[3], 32'h55);

        // Reset while the stage is full and held
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd0, OP_WRITE, 32'h77);
        tick(); idle();
        #1 chk("t6 full", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6 rst valid", rsp_valid, 0);
        chk("t6 rst write", reg_write, 0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6 bank0 kept", bank[0], INIT0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
